word_serializer: RTL and testbench

//  Upstream feeder for the bit-serial two's-complement stage (invert). Accepts a parallel
//  W-bit word on a valid/ready handshake and emits it LSB-first, one bit per t_clk.

---
 rtl/word_serializer_pkg.sv | 13 +
 rtl/word_serializer.sv | 108 ++++++++++
 tb/tb_word_serializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM encoding and default word width.
// The encoding values match the downstream deserializer's view of the stream.
package word_serializer_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder for the bit-serial two's-complement stage: LSB first, with a
// one-cycle downstream clear (ser_r) ahead of every word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no word in flight; ser_r held high, ready to accept
// ST_CLR   | one-cycle clear of the downstream stage before bit 0
// ST_SHIFT | emitting bits 0..W-1; may accept the next word on bit W-1
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         ser_i,
  output logic         ser_r,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [W-1:0]   shreg, shreg_nxt;
  logic           ser_i_d, ser_r_d, ser_valid_d, ser_last_d;
  logic           on_last;
  logic           accept;

  assign on_last   = (state == ST_SHIFT) && (cnt == CNT_LAST);
  assign din_ready = ((state == ST_IDLE) || on_last) && !r;
  assign accept    = din_valid && din_ready;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge t_clk) begin
    if (r) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ser_i     <= 1'b0;
      ser_r     <= 1'b1;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      ser_i     <= ser_i_d;
      ser_r     <= ser_r_d;
      ser_valid <= ser_valid_d;
      ser_last  <= ser_last_d;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          shreg_nxt = din;
          state_nxt = ST_CLR;
        end
      end
      ST_CLR: begin
        cnt_nxt   = '0;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_nxt = shreg >> 1;
        if (cnt == CNT_LAST) begin
          // cnt is left at W-1 here; only the clear cycle rewinds it
          if (accept) begin
            shreg_nxt = din;
            state_nxt = ST_CLR;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    ser_i_d     = 1'b0;
    ser_r_d     = 1'b1;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    if (state_nxt == ST_SHIFT) begin
      ser_i_d     = shreg_nxt[0];
      ser_r_d     = 1'b0;
      ser_valid_d = 1'b1;
      ser_last_d  = (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (W=8), including a behavioural bit-serial
// two's-complement stage on the serial outputs for end-to-end checks.
module tb_word_serializer;

  logic       t_clk = 1'b0;
  logic       r = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready, ser_i, ser_r, ser_valid, ser_last, busy;

  int n_cmp = 0;
  int n_err = 0;

  word_serializer #(.W(8)) dut (
    .t_clk(t_clk), .r(r), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ser_i(ser_i), .ser_r(ser_r), .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy)
  );

  always #5 t_clk = ~t_clk;

  // Downstream invert stage: pass bits up to and including the first 1, invert after it
  logic inv_seen = 1'b0;
  always_ff @(posedge t_clk) begin
    if (ser_r) inv_seen <= 1'b0;
    else if (ser_valid && ser_i) inv_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge t_clk);
  endtask

  task automatic check_clr(input string tag);
    check({tag, "_clr_ser_r"}, 8'(ser_r), 8'd1);
    check({tag, "_clr_valid"}, 8'(ser_valid), 8'd0);
    check({tag, "_clr_ser_i"}, 8'(ser_i), 8'd0);
    check({tag, "_clr_busy"}, 8'(busy), 8'd1);
    check({tag, "_clr_ready"}, 8'(din_ready), 8'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_ser_r"}, 8'(ser_r), 8'd1);
    check({tag, "_idle_valid"}, 8'(ser_valid), 8'd0);
    check({tag, "_idle_busy"}, 8'(busy), 8'd0);
    check({tag, "_idle_ready"}, 8'(din_ready), 8'd1);
  endtask

  // Entered at the negedge of the clear cycle; leaves at the negedge of bit 7
  task automatic stream_word(input string tag, input logic [7:0] w, output logic [7:0] y);
    y = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("%s_bit%0d", tag, i), 8'(ser_i), 8'(w[i]));
      check($sformatf("%s_valid%0d", tag, i), 8'(ser_valid), 8'd1);
      check($sformatf("%s_ser_r%0d", tag, i), 8'(ser_r), 8'd0);
      check($sformatf("%s_last%0d", tag, i), 8'(ser_last), (i == 7) ? 8'd1 : 8'd0);
      check($sformatf("%s_ready%0d", tag, i), 8'(din_ready), (i == 7) ? 8'd1 : 8'd0);
      y[i] = ser_i ^ inv_seen;
    end
  endtask

  logic [7:0] y;
  int         valid_cycles;
  int         clr_cycles;

  initial begin
    // reset
    step(); step();
    check("rst_ser_i", 8'(ser_i), 8'd0);
    check("rst_ser_r", 8'(ser_r), 8'd1);
    check("rst_valid", 8'(ser_valid), 8'd0);
    check("rst_last", 8'(ser_last), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_ready_in_reset", 8'(din_ready), 8'd0);
    r = 1'b0;
    #1 check("rst_ready_after", 8'(din_ready), 8'd1);

    // single word 8'hB4
    din = 8'hB4; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check_clr("b4");
    stream_word("b4", 8'hB4, y);
    step();
    check_idle("b4");

    // back-to-back 8'h0F then 8'hF0 with din_valid held
    din = 8'h0F; din_valid = 1'b1;
    valid_cycles = 0; clr_cycles = 0;
    step();
    din = 8'hF0;
    check_clr("w0f");
    clr_cycles++;
    stream_word("w0f", 8'h0F, y);
    valid_cycles += 8;
    step();
    din_valid = 1'b0;
    check_clr("wf0");
    clr_cycles++;
    stream_word("wf0", 8'hF0, y);
    valid_cycles += 8;
    check("b2b_total_cycles", 8'(valid_cycles + clr_cycles), 8'd18);
    step();
    check_idle("wf0");

    // reset mid-word, then reset colliding with din_valid
    din = 8'hFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step(); step(); step();
    check("rst_mid_bit2", 8'(ser_i), 8'd1);
    r = 1'b1;
    step();
    check("rstmid_valid", 8'(ser_valid), 8'd0);
    check("rstmid_ser_r", 8'(ser_r), 8'd1);
    check("rstmid_busy", 8'(busy), 8'd0);
    check("rstmid_last", 8'(ser_last), 8'd0);
    check("rstmid_ready", 8'(din_ready), 8'd0);
    din = 8'h3C; din_valid = 1'b1;
    step();
    check("rstcol_no_accept", 8'(busy), 8'd0);
    check("rstcol_ready", 8'(din_ready), 8'd0);
    r = 1'b0;
    #1 check("rstcol_ready_after", 8'(din_ready), 8'd1);
    step();
    din_valid = 1'b0;
    check_clr("w3c");
    stream_word("w3c", 8'h3C, y);
    step();
    check_idle("w3c");

    // din changes mid-word must not disturb the word in flight
    din = 8'h55; din_valid = 1'b1;
    step();
    din = 8'hAA;
    check_clr("w55");
    stream_word("w55", 8'h55, y);
    step();
    din_valid = 1'b0;
    check_clr("waa");
    stream_word("waa", 8'hAA, y);
    step();
    check_idle("waa");

    // end-to-end through the two's-complement stage
    din = 8'h06; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    stream_word("e06", 8'h06, y);
    check("inv_06", y, 8'hFA);
    step();
    din = 8'h00; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    stream_word("e00", 8'h00, y);
    check("inv_00", y, 8'h00);
    step();
    din = 8'h80; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    stream_word("e80", 8'h80, y);
    check("inv_80", y, 8'h80);
    step();
    check_idle("e80");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
